serial_frame_rx: RTL

//  Framed serial receiver. Sits directly downstream of the D flip-flop stage
//  (D_flip): its data_in is that stage's registered data_out.

---
 rtl/serial_frame_rx.sv | 121 ++++++++++++
 1 files changed

// File: rtl/serial_frame_rx.sv
// Framed serial receiver: start bit, WIDTH data bits (LSB first), optional
// parity bit and stop bit, qualified by bit_en. Emits a word with a valid pulse.
module serial_frame_rx #(
    parameter int WIDTH      = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             data_in,
    input  logic             bit_en,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             parity_err,
    output logic             frame_err,
    output logic             busy,
    output logic [7:0]       frame_count
);

    localparam int              CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);
    localparam logic            P_EN   = (PARITY_EN != 0);
    localparam logic            P_ODD  = (PARITY_ODD != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_shreg;
    logic               r_p_rx;
    logic [WIDTH-1:0]   r_data_out;
    logic               r_valid;
    logic               r_parity_err;
    logic               r_frame_err;
    logic               r_busy;
    logic [7:0]         r_frame_count;

    logic [WIDTH-1:0]   w_bit_sel;
    logic               w_parity_err;

    // One-hot write enable for the shift register slot addressed by the counter.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit_sel
        assign w_bit_sel[gi] = (r_state == DATA) && bit_en && (r_cnt == CNT_W'(gi));
    end

    assign w_parity_err = P_EN && ((^r_shreg ^ r_p_rx) != P_ODD);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_shreg <= '0;
        end else begin
            r_shreg <= (r_shreg & ~w_bit_sel) | ({WIDTH{data_in}} & w_bit_sel);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_p_rx        <= 1'b0;
            r_data_out    <= '0;
            r_valid       <= 1'b0;
            r_parity_err  <= 1'b0;
            r_frame_err   <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_count <= 8'd0;
        end else begin
            r_valid <= 1'b0;
            if (bit_en) begin
                case (r_state)
                    IDLE: begin
                        if (data_in) begin
                            r_state <= DATA;
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                        end
                    end
                    DATA: begin
                        if (r_cnt == LAST) begin
                            r_cnt   <= '0;
                            r_state <= P_EN ? PARITY : STOP;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    PARITY: begin
                        r_p_rx  <= data_in;
                        r_state <= STOP;
                    end
                    STOP: begin
                        // The stop bit is consumed here; a 1 is never reused as a start bit.
                        r_state       <= IDLE;
                        r_busy        <= 1'b0;
                        r_data_out    <= r_shreg;
                        r_valid       <= 1'b1;
                        r_frame_err   <= data_in;
                        r_parity_err  <= w_parity_err;
                        r_frame_count <= r_frame_count + 8'd1;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign data_out    = r_data_out;
    assign valid       = r_valid;
    assign parity_err  = r_parity_err;
    assign frame_err   = r_frame_err;
    assign busy        = r_busy;
    assign frame_count = r_frame_count;

endmodule
